udp_header_rx: RTL and testbench

//  Downstream stage of the IP header receiver. Arms on ip_header_done, parses the 8-byte UDP

---
 rtl/eth_pkg.sv | 21 ++
 rtl/udp_header_rx.sv | 170 +++++++++++++++++
 tb/tb_udp_header_rx.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet/IP/UDP receive stages.
`timescale 1ns/1ps
package eth_pkg;

  // UDP header parser states
  typedef enum logic [2:0] {
    UDP_IDLE     = 3'd0,
    UDP_SRC_PORT = 3'd1,
    UDP_DST_PORT = 3'd2,
    UDP_LENGTH   = 3'd3,
    UDP_CHECKSUM = 3'd4,
    UDP_PAYLOAD  = 3'd5,
    UDP_DROP     = 3'd6
  } udp_state_t;

  localparam int UDP_HDR_LEN        = 8;
  localparam int UDP_PORT_BYTES     = 2;
  localparam int UDP_LENGTH_BYTES   = 2;
  localparam int UDP_CHECKSUM_BYTES = 2;

endpackage

// File: rtl/udp_header_rx.sv
// UDP header receiver: parses the 8-byte UDP header following the IP header,
// filters on source/destination port, validates the length and forwards the
// payload bytes one clock later with tlast on the final byte.
//
// Handshake: there is no backpressure. m_tvalid qualifies m_tdata for exactly
// one cycle per byte; the consumer must accept every beat. m_tlast is only
// ever high together with m_tvalid.
`timescale 1ns/1ps
module udp_header_rx
  import eth_pkg::*;
#(
  parameter int MAX_UDP_LEN = 1480,
  parameter int MIN_UDP_LEN = 8
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  input  logic        ip_header_done,
  input  logic [15:0] udp_s_port,
  input  logic [15:0] udp_d_port,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  output logic        m_tlast,
  output logic [15:0] udp_len,
  output logic [15:0] udp_checksum,
  output logic        udp_header_done,
  output logic        udp_err,
  output logic [2:0]  dbg_state
);

  udp_state_t  state_q, state_d;
  logic        cnt_q, cnt_d;          // byte index within a 2-byte header field
  logic [7:0]  msb_q, msb_d;          // high byte of the field being assembled
  logic [15:0] len_q, len_d;          // length field, pending until header completes
  logic [15:0] remain_q, remain_d;    // payload bytes still to forward
  logic [15:0] udp_len_q, udp_len_d;
  logic [15:0] csum_q, csum_d;
  logic [7:0]  m_tdata_q, m_tdata_d;
  logic        m_tvalid_q, m_tvalid_d;
  logic        m_tlast_q, m_tlast_d;
  logic        hdr_done_q, hdr_done_d;
  logic        err_q, err_d;
  logic [15:0] word;

  assign word = {msb_q, data_in};

  // Next-state and output computation for the header/payload parser
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    msb_d      = msb_q;
    len_d      = len_q;
    remain_d   = remain_q;
    udp_len_d  = udp_len_q;
    csum_d     = csum_q;
    m_tdata_d  = m_tdata_q;
    m_tvalid_d = 1'b0;
    m_tlast_d  = 1'b0;
    hdr_done_d = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      UDP_IDLE: begin
        if (ip_header_done && data_valid) begin
          msb_d   = data_in;
          cnt_d   = 1'b1;
          state_d = UDP_SRC_PORT;
        end
      end

      UDP_SRC_PORT, UDP_DST_PORT, UDP_LENGTH, UDP_CHECKSUM: begin
        if (!data_valid) begin
          // Stream ended inside the header: abort and report
          state_d = UDP_IDLE;
          cnt_d   = 1'b0;
          err_d   = 1'b1;
        end else if (!cnt_q) begin
          msb_d = data_in;
          cnt_d = 1'b1;
        end else begin
          cnt_d = 1'b0;
          case (state_q)
            UDP_SRC_PORT: state_d = (word == udp_s_port) ? UDP_DST_PORT : UDP_DROP;
            UDP_DST_PORT: state_d = (word == udp_d_port) ? UDP_LENGTH : UDP_DROP;
            UDP_LENGTH: begin
              if ((word < 16'(MIN_UDP_LEN)) || (word > 16'(MAX_UDP_LEN))) begin
                state_d = UDP_DROP;
              end else begin
                // word >= 8 is guaranteed here, so the subtraction cannot wrap
                len_d    = word;
                remain_d = word - 16'(UDP_HDR_LEN);
                state_d  = UDP_CHECKSUM;
              end
            end
            default: begin
              udp_len_d  = len_q;
              csum_d     = word;
              hdr_done_d = 1'b1;
              state_d    = (remain_q == 16'd0) ? UDP_IDLE : UDP_PAYLOAD;
            end
          endcase
        end
      end

      UDP_PAYLOAD: begin
        if (!data_valid) begin
          state_d = UDP_IDLE;
          err_d   = 1'b1;
        end else begin
          m_tdata_d  = data_in;
          m_tvalid_d = 1'b1;
          remain_d   = remain_q - 16'd1;
          if (remain_q == 16'd1) begin
            m_tlast_d = 1'b1;
            state_d   = UDP_IDLE;
          end
        end
      end

      UDP_DROP: begin
        // Filtered datagram: swallow bytes until the frame ends
        if (!data_valid) state_d = UDP_IDLE;
      end

      default: state_d = UDP_IDLE;
    endcase
  end

  // State and registered outputs; reset discards any datagram in flight
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= UDP_IDLE;
      cnt_q      <= 1'b0;
      msb_q      <= 8'd0;
      len_q      <= 16'd0;
      remain_q   <= 16'd0;
      udp_len_q  <= 16'd0;
      csum_q     <= 16'd0;
      m_tdata_q  <= 8'd0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      hdr_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      msb_q      <= msb_d;
      len_q      <= len_d;
      remain_q   <= remain_d;
      udp_len_q  <= udp_len_d;
      csum_q     <= csum_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      hdr_done_q <= hdr_done_d;
      err_q      <= err_d;
    end
  end

  assign m_tdata         = m_tdata_q;
  assign m_tvalid        = m_tvalid_q;
  assign m_tlast         = m_tlast_q;
  assign udp_len         = udp_len_q;
  assign udp_checksum    = csum_q;
  assign udp_header_done = hdr_done_q;
  assign udp_err         = err_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_udp_header_rx.sv
// Testbench for udp_header_rx: directed frames, payload scoreboard.
`timescale 1ns/1ps
module tb_udp_header_rx;

  logic        aclk = 1'b0;
  logic        areset;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        ip_header_done;
  logic [15:0] udp_s_port;
  logic [15:0] udp_d_port;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic [15:0] udp_len;
  logic [15:0] udp_checksum;
  logic        udp_header_done;
  logic        udp_err;
  logic [2:0]  dbg_state;

  udp_header_rx dut (
    .aclk(aclk), .areset(areset), .data_in(data_in), .data_valid(data_valid),
    .ip_header_done(ip_header_done), .udp_s_port(udp_s_port), .udp_d_port(udp_d_port),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .udp_len(udp_len),
    .udp_checksum(udp_checksum), .udp_header_done(udp_header_done), .udp_err(udp_err),
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int hdr_cnt = 0;
  int err_cnt = 0;
  int beat_cnt = 0;
  logic [8:0]  exp_q[$];      // {tlast, tdata}
  logic [7:0]  pay[$];        // optional fixed payload for the next frame
  logic [15:0] last_cs;
  logic        dv_s = 1'b0;
  int h0, e0, b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // data_valid as seen by the DUT at the last rising edge
  always @(posedge aclk) dv_s <= data_valid;

  // Output monitor / scoreboard
  always @(negedge aclk) begin
    if (!areset) begin
      if (udp_header_done) hdr_cnt++;
      if (udp_err) err_cnt++;
      if (m_tlast && !m_tvalid) check("tlast_without_tvalid", 32'(m_tvalid), 32'd1);
      if (m_tvalid) begin
        beat_cnt++;
        check("tvalid_after_valid_low", 32'(dv_s), 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_beat_queue_size", 32'(exp_q.size()), 32'd1);
        end else begin
          check("beat", 32'({m_tlast, m_tdata}), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // Driver: apply one byte, wait one edge
  task automatic drive(input logic [7:0] d, input logic v, input logic h);
    data_in        = d;
    data_valid     = v;
    ip_header_done = h;
    @(posedge aclk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) drive(8'h00, 1'b0, 1'b0);
  endtask

  // Header followed by n_after valid bytes; expected beats pushed if accepted
  task automatic send_frame(input logic [15:0] sp, input logic [15:0] dp,
                            input logic [15:0] len, input int n_after, input bit accept);
    logic [7:0]  hdr[8];
    logic [15:0] cs;
    logic [7:0]  b;
    cs  = 16'($urandom_range(0, 65535));
    hdr = '{sp[15:8], sp[7:0], dp[15:8], dp[7:0], len[15:8], len[7:0], cs[15:8], cs[7:0]};
    for (int i = 0; i < 8; i++) drive(hdr[i], 1'b1, i == 0);
    for (int i = 0; i < n_after; i++) begin
      b = (i < pay.size()) ? pay[i] : 8'($urandom_range(0, 255));
      if (accept && (i < int'(len) - 8)) exp_q.push_back({(i == int'(len) - 9), b});
      drive(b, 1'b1, 1'b0);
    end
    if (accept) last_cs = cs;
    pay.delete();
  endtask

  task automatic snap();
    h0 = hdr_cnt; e0 = err_cnt; b0 = beat_cnt;
  endtask

  initial begin
    areset = 1'b1; data_in = 8'h00; data_valid = 1'b0; ip_header_done = 1'b0;
    udp_s_port = 16'h1234; udp_d_port = 16'h5678; last_cs = 16'h0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tlast", 32'(m_tlast), 32'd0);
    check("rst_tdata", 32'(m_tdata), 32'd0);
    check("rst_len", 32'(udp_len), 32'd0);
    check("rst_csum", 32'(udp_checksum), 32'd0);
    check("rst_hdr_done", 32'(udp_header_done), 32'd0);
    check("rst_err", 32'(udp_err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    areset = 1'b0;
    gap(2);

    // 1: basic datagram
    snap();
    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(16'h1234, 16'h5678, 16'h000C, 4, 1'b1);
    gap(3);
    check("t1_hdr_done", 32'(hdr_cnt - h0), 32'd1);
    check("t1_beats", 32'(beat_cnt - b0), 32'd4);
    check("t1_err", 32'(err_cnt - e0), 32'd0);
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t1_udp_len", 32'(udp_len), 32'h000C);
    check("t1_csum", 32'(udp_checksum), 32'(last_cs));

    // 2: destination port mismatch, then a good frame
    snap();
    send_frame(16'h1234, 16'h5679, 16'h000C, 4, 1'b0);
    gap(3);
    check("t2_drop_hdr_done", 32'(hdr_cnt - h0), 32'd0);
    check("t2_drop_beats", 32'(beat_cnt - b0), 32'd0);
    check("t2_drop_err", 32'(err_cnt - e0), 32'd0);
    snap();
    send_frame(16'h1234, 16'h5678, 16'h000E, 6, 1'b1);
    gap(3);
    check("t2_good_hdr_done", 32'(hdr_cnt - h0), 32'd1);
    check("t2_good_beats", 32'(beat_cnt - b0), 32'd6);
    check("t2_good_len", 32'(udp_len), 32'h000E);

    // 3: length boundaries
    snap();
    send_frame(16'h1234, 16'h5678, 16'h0008, 0, 1'b1);
    gap(3);
    check("t3_len8_hdr_done", 32'(hdr_cnt - h0), 32'd1);
    check("t3_len8_beats", 32'(beat_cnt - b0), 32'd0);
    check("t3_len8_len", 32'(udp_len), 32'h0008);
    snap();
    send_frame(16'h1234, 16'h5678, 16'h0007, 3, 1'b0);
    gap(3);
    send_frame(16'h1234, 16'h5678, 16'h05C9, 3, 1'b0);
    gap(3);
    check("t3_bad_len_hdr_done", 32'(hdr_cnt - h0), 32'd0);
    check("t3_bad_len_beats", 32'(beat_cnt - b0), 32'd0);
    check("t3_bad_len_err", 32'(err_cnt - e0), 32'd0);
    check("t3_bad_len_len_held", 32'(udp_len), 32'h0008);
    snap();
    send_frame(16'h1234, 16'h5678, 16'h05C8, 1472, 1'b1);
    gap(3);
    check("t3_max_hdr_done", 32'(hdr_cnt - h0), 32'd1);
    check("t3_max_beats", 32'(beat_cnt - b0), 32'd1472);
    check("t3_max_len", 32'(udp_len), 32'h05C8);

    // 4: trailing padding ignored
    snap();
    send_frame(16'h1234, 16'h5678, 16'h000A, 20, 1'b1);
    gap(3);
    check("t4_beats", 32'(beat_cnt - b0), 32'd2);
    check("t4_err", 32'(err_cnt - e0), 32'd0);
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // 5: data_valid drops mid-payload
    snap();
    send_frame(16'h1234, 16'h5678, 16'h0012, 3, 1'b1);
    gap(3);
    check("t5_beats", 32'(beat_cnt - b0), 32'd3);
    check("t5_err", 32'(err_cnt - e0), 32'd1);
    check("t5_state_idle", 32'(dbg_state), 32'd0);
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    // 6: reset mid-payload, then a back-to-back frame
    send_frame(16'h1234, 16'h5678, 16'h0012, 4, 1'b1);
    areset = 1'b1;
    #1;
    check("t6_rst_tvalid", 32'(m_tvalid), 32'd0);
    check("t6_rst_tdata", 32'(m_tdata), 32'd0);
    check("t6_rst_tlast", 32'(m_tlast), 32'd0);
    check("t6_rst_len", 32'(udp_len), 32'd0);
    exp_q.delete();
    @(posedge aclk);
    #1;
    areset = 1'b0;
    snap();
    send_frame(16'h1234, 16'h5678, 16'h000C, 4, 1'b1);
    gap(3);
    check("t6_next_hdr_done", 32'(hdr_cnt - h0), 32'd1);
    check("t6_next_beats", 32'(beat_cnt - b0), 32'd4);
    check("t6_next_err", 32'(err_cnt - e0), 32'd0);
    check("t6_next_len", 32'(udp_len), 32'h000C);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
